// File: rtl/mant_normalizer_if.sv
// Handshake and result bundle between the mantissa ALU, the normalizer and the packing stage.
interface mant_normalizer_if #(
    parameter int MW = 10,
    parameter int EW = 5
);
    logic          start;
    logic [MW+1:0] mant_in;
    logic [EW-1:0] exp_in;
    logic          busy;
    logic          done;
    logic [MW-1:0] mant_out;
    logic [EW-1:0] exp_out;
    logic          zero;
    logic          underflow;
    logic          overflow;

    modport master (
        output start, mant_in, exp_in,
        input  busy, done, mant_out, exp_out, zero, underflow, overflow
    );

    modport slave (
        input  start, mant_in, exp_in,
        output busy, done, mant_out, exp_out, zero, underflow, overflow
    );
endinterface

// File: rtl/mant_normalizer.sv
// Post-subtraction mantissa normalizer: one bit position per cycle, then packs fraction, exponent and flags.
module mant_normalizer #(
    parameter int MW   = 10,
    parameter int EW   = 5,
    parameter int EMAX = 31
) (
    input  logic             clk,
    input  logic             rst,
    mant_normalizer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [EW-1:0] E_MAX = EW'(EMAX);
    localparam logic [EW-1:0] E_ONE = EW'(1);

    state_t        state, state_n;
    logic [MW+1:0] m, m_n, m_sh;
    logic [EW-1:0] e, e_n, e_inc;
    logic [MW-1:0] mant_q, mant_n;
    logic [EW-1:0] exp_q, exp_n;
    logic          zero_q, zero_n;
    logic          uf_q, uf_n;
    logic          of_q, of_n;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_n = state;
        m_n     = m;
        e_n     = e;
        mant_n  = mant_q;
        exp_n   = exp_q;
        zero_n  = zero_q;
        uf_n    = uf_q;
        of_n    = of_q;
        m_sh    = m >> 1;
        e_inc   = e + E_ONE;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    m_n     = bus.mant_in;
                    e_n     = bus.exp_in;
                    zero_n  = 1'b0;
                    uf_n    = 1'b0;
                    of_n    = 1'b0;
                    state_n = NORM;
                end
            end
            NORM: begin
                state_n = DONE;
                if (e == E_MAX) begin
                    of_n   = 1'b1;
                    mant_n = '0;
                    exp_n  = E_MAX;
                end else if (m == '0) begin
                    zero_n = 1'b1;
                    mant_n = '0;
                    exp_n  = '0;
                end else if (m[MW+1]) begin
                    // Carry out: drop the LSB without rounding, saturate to Inf on exponent overflow.
                    m_n = m_sh;
                    e_n = e_inc;
                    if (e_inc == E_MAX) begin
                        of_n   = 1'b1;
                        mant_n = '0;
                        exp_n  = E_MAX;
                    end else begin
                        mant_n = m_sh[MW-1:0];
                        exp_n  = e_inc;
                    end
                end else if (m[MW]) begin
                    mant_n = m[MW-1:0];
                    exp_n  = e;
                end else if (e <= E_ONE) begin
                    // Exponent floor reached before the hidden bit: emit as denormal, never wrap.
                    uf_n   = 1'b1;
                    mant_n = m[MW-1:0];
                    exp_n  = '0;
                end else begin
                    m_n     = m << 1;
                    e_n     = e - E_ONE;
                    state_n = NORM;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            m      <= '0;
            e      <= '0;
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
            of_q   <= 1'b0;
        end else begin
            state  <= state_n;
            m      <= m_n;
            e      <= e_n;
            mant_q <= mant_n;
            exp_q  <= exp_n;
            zero_q <= zero_n;
            uf_q   <= uf_n;
            of_q   <= of_n;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.mant_out  = mant_q;
    assign bus.exp_out   = exp_q;
    assign bus.zero      = zero_q;
    assign bus.underflow = uf_q;
    assign bus.overflow  = of_q;
endmodule

// File: tb/tb_mant_normalizer.sv
// Randomized scoreboard bench for mant_normalizer against a shift-count reference model.
module tb_mant_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [9:0] mant;
        logic [4:0] ex;
        logic       z;
        logic       uf;
        logic       of;
        int         lat;
        int         sc;
    } res_t;

    res_t sb[$];

    mant_normalizer_if bus ();

    mant_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference: shifts needed to reach the hidden bit, capped by how far the exponent may fall.
    function automatic res_t model(input logic [11:0] m, input logic [4:0] e);
        res_t        r;
        logic [11:0] mm;
        int          p, s, k;
        r.mant = '0; r.ex = '0; r.z = 1'b0; r.uf = 1'b0; r.of = 1'b0; r.lat = 2; r.sc = 0;
        if (e == 5'd31) begin
            r.of = 1'b1; r.ex = 5'd31;
        end else if (m == 12'd0) begin
            r.z = 1'b1;
        end else if (m >= 12'h800) begin
            if (int'(e) + 1 == 31) begin
                r.of = 1'b1; r.ex = 5'd31;
            end else begin
                mm = m >> 1; r.mant = mm[9:0]; r.ex = e + 5'd1;
            end
        end else if (m >= 12'h400) begin
            r.mant = m[9:0]; r.ex = e;
        end else begin
            p = 0;
            for (int i = 0; i < 10; i++) if (m[i]) p = i;
            s = 10 - p;
            k = (int'(e) >= 1) ? ((s < int'(e) - 1) ? s : int'(e) - 1) : 0;
            mm = m << k;
            r.mant = mm[9:0];
            if (k == s) r.ex = 5'(int'(e) - k);
            else begin r.uf = 1'b1; r.ex = 5'd0; end
            r.lat = k + 2;
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cycle);
            end else begin
                res_t x;
                x = sb.pop_front();
                check("mant_out", 32'(bus.mant_out), 32'(x.mant));
                check("exp_out", 32'(bus.exp_out), 32'(x.ex));
                check("zero", 32'(bus.zero), 32'(x.z));
                check("underflow", 32'(bus.underflow), 32'(x.uf));
                check("overflow", 32'(bus.overflow), 32'(x.of));
                check("latency", 32'(cycle - x.sc), 32'(x.lat));
            end
        end
    end

    task automatic wait_done(input res_t x);
        int n = 0;
        while (!bus.done && n < 20) begin
            check("busy_during_op", 32'(bus.busy), 32'd1);
            @(negedge clk);
            n++;
        end
        if (!bus.done) check("done_timeout", 32'd0, 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("hold_mant", 32'(bus.mant_out), 32'(x.mant));
        check("hold_exp", 32'(bus.exp_out), 32'(x.ex));
        check("hold_flags", {29'd0, bus.zero, bus.underflow, bus.overflow}, {29'd0, x.z, x.uf, x.of});
    endtask

    // Called at a negedge while IDLE; returns at a negedge while IDLE.
    task automatic run_op(input logic [11:0] m, input logic [4:0] e);
        res_t x;
        x = model(m, e);
        x.sc = cycle;
        sb.push_back(x);
        bus.start = 1'b1; bus.mant_in = m; bus.exp_in = e;
        @(negedge clk);
        bus.start = 1'b0; bus.mant_in = 12'($urandom); bus.exp_in = 5'($urandom);
        @(negedge clk);
        wait_done(x);
    endtask

    initial begin
        logic [11:0] rm;
        logic [4:0]  re;
        res_t        x;

        bus.start = 1'b0; bus.mant_in = '0; bus.exp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mant", 32'(bus.mant_out), 32'd0);
        check("rst_exp", 32'(bus.exp_out), 32'd0);
        check("rst_flags", {29'd0, bus.zero, bus.underflow, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases
        run_op(12'h400, 5'd15);
        run_op(12'hC01, 5'd15);
        run_op(12'h001, 5'd20);
        run_op(12'h040, 5'd3);
        run_op(12'h800, 5'd30);
        run_op(12'h000, 5'd9);
        run_op(12'h123, 5'd31);
        run_op(12'h200, 5'd1);
        run_op(12'h200, 5'd0);
        run_op(12'h001, 5'd11);

        // Start pulsed mid-operation must be ignored
        x = model(12'h001, 5'd20);
        x.sc = cycle;
        sb.push_back(x);
        bus.start = 1'b1; bus.mant_in = 12'h001; bus.exp_in = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.mant_in = 12'hC01; bus.exp_in = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(x);

        // Reset mid-operation: outputs clear and no done for the aborted op
        bus.start = 1'b1; bus.mant_in = 12'h001; bus.exp_in = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_mant", 32'(bus.mant_out), 32'd0);
        check("abort_exp", 32'(bus.exp_out), 32'd0);
        check("abort_flags", {29'd0, bus.zero, bus.underflow, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check("abort_no_busy", 32'(bus.busy), 32'd0);

        // Randomized operations across mantissa classes and exponent extremes
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0:       rm = 12'($urandom);
                1:       rm = 12'($urandom) >> $urandom_range(2, 11);
                2:       rm = 12'h0;
                3:       rm = 12'h800 | 12'($urandom_range(0, 12'h7FF));
                default: rm = 12'h400 | 12'($urandom_range(0, 12'h3FF));
            endcase
            case ($urandom_range(0, 5))
                0:       re = 5'($urandom_range(0, 2));
                1:       re = 5'($urandom_range(29, 31));
                default: re = 5'($urandom);
            endcase
            run_op(rm, re);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
